// File: rtl/bp_cce_mshr_bank.sv
// Multi-entry MSHR bank for the CCE: allocation with block-address conflict
// detection, stall-gated ucode field writes, directory LRU writeback and free.
module bp_cce_mshr_bank #(
    parameter int num_mshr_p               = 4,
    parameter int lce_id_width_p           = 4,
    parameter int paddr_width_p            = 40,
    parameter int lce_assoc_width_p        = 3,
    parameter int num_flags_p              = 16,
    parameter int lg_block_size_in_bytes_p = 6,
    parameter int lef_flag_idx_p           = 15,
    localparam int id_w  = (num_mshr_p > 1) ? $clog2(num_mshr_p) : 1,
    localparam int cnt_w = $clog2(num_mshr_p + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         stall_i,

    input  logic                         alloc_v_i,
    input  logic [lce_id_width_p-1:0]    alloc_lce_id_i,
    input  logic [paddr_width_p-1:0]     alloc_paddr_i,
    input  logic [lce_assoc_width_p-1:0] alloc_lru_way_i,
    input  logic [num_flags_p-1:0]       alloc_flags_i,
    output logic                         alloc_ready_o,
    output logic [id_w-1:0]              alloc_id_o,
    output logic                         conflict_o,

    input  logic [id_w-1:0]              wr_id_i,
    input  logic [4:0]                   wr_field_mask_i,
    input  logic [num_flags_p-1:0]       wr_flag_mask_i,
    input  logic [lce_id_width_p-1:0]    wr_lce_id_i,
    input  logic [paddr_width_p-1:0]     wr_paddr_i,
    input  logic [lce_assoc_width_p-1:0] wr_way_i,
    input  logic [lce_assoc_width_p-1:0] wr_lru_way_i,
    input  logic [2:0]                   wr_coh_state_i,
    input  logic [num_flags_p-1:0]       wr_flags_i,

    input  logic                         dir_lru_v_i,
    input  logic [paddr_width_p-1:0]     dir_lru_addr_i,
    input  logic                         dir_lru_cached_excl_i,

    input  logic                         free_v_i,
    input  logic [id_w-1:0]              free_id_i,

    input  logic [id_w-1:0]              rd_id_i,
    output logic [lce_id_width_p-1:0]    rd_lce_id_o,
    output logic [paddr_width_p-1:0]     rd_paddr_o,
    output logic [lce_assoc_width_p-1:0] rd_way_o,
    output logic [lce_assoc_width_p-1:0] rd_lru_way_o,
    output logic [paddr_width_p-1:0]     rd_lru_paddr_o,
    output logic [2:0]                   rd_coh_state_o,
    output logic [num_flags_p-1:0]       rd_flags_o,

    output logic [num_mshr_p-1:0]        valid_o,
    output logic [cnt_w-1:0]             count_o,
    output logic                         empty_o,
    output logic                         full_o
);

    typedef struct packed {
        logic [lce_id_width_p-1:0]    lce_id;
        logic [paddr_width_p-1:0]     paddr;
        logic [lce_assoc_width_p-1:0] way_id;
        logic [lce_assoc_width_p-1:0] lru_way_id;
        logic [paddr_width_p-1:0]     lru_paddr;
        logic [2:0]                   coh_state;
        logic [num_flags_p-1:0]       flags;
    } entry_t;

    localparam logic [2:0] e_coh_i = 3'd0;
    localparam int blk_lo = lg_block_size_in_bytes_p;

    logic [num_mshr_p-1:0] r_valid;
    entry_t                r_entry [num_mshr_p];
    logic [cnt_w-1:0]      r_count;

    logic [num_mshr_p-1:0] w_valid_nxt;
    entry_t                w_entry_nxt [num_mshr_p];
    logic [id_w-1:0]       w_alloc_id;
    logic                  w_found;
    logic                  w_conflict;
    logic                  w_full;
    logic                  w_alloc_fire;
    logic                  w_free_eff;
    entry_t                w_rd;

    // Free-slot search, conflict compare and effective-free detection over pre-edge state.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
        w_alloc_id = '0;
        w_found    = 1'b0;
        w_conflict = 1'b0;
        w_free_eff = 1'b0;
        for (int i = 0; i < num_mshr_p; i++) begin
            if (!r_valid[i] && !w_found) begin
                w_alloc_id = id_w'(i);
                w_found    = 1'b1;
            end
            if (r_valid[i] && (r_entry[i].paddr[paddr_width_p-1:blk_lo] ==
                               alloc_paddr_i[paddr_width_p-1:blk_lo]))
                w_conflict = 1'b1;
            if (free_v_i && (free_id_i == id_w'(i)) && r_valid[i])
                w_free_eff = 1'b1;
        end
    end

    assign w_full       = (r_count == cnt_w'(num_mshr_p));
    assign w_alloc_fire = alloc_v_i & ~w_full & ~w_conflict;

    // Next-state per entry; free beats directory write, which beats ucode write.
    always_comb begin
        for (int i = 0; i < num_mshr_p; i++) begin
            w_valid_nxt[i] = r_valid[i];
            w_entry_nxt[i] = r_entry[i];
            if (w_alloc_fire && (w_alloc_id == id_w'(i))) begin
                w_valid_nxt[i]            = 1'b1;
                w_entry_nxt[i].lce_id     = alloc_lce_id_i;
                w_entry_nxt[i].paddr      = alloc_paddr_i;
                w_entry_nxt[i].way_id     = '0;
                w_entry_nxt[i].lru_way_id = alloc_lru_way_i;
                w_entry_nxt[i].lru_paddr  = '0;
                w_entry_nxt[i].coh_state  = e_coh_i;
                w_entry_nxt[i].flags      = alloc_flags_i;
            end else if (r_valid[i]) begin
                if (free_v_i && (free_id_i == id_w'(i))) begin
                    w_valid_nxt[i] = 1'b0;
                end else if (wr_id_i == id_w'(i)) begin
                    if (!stall_i) begin
                        if (wr_field_mask_i[0]) w_entry_nxt[i].lce_id     = wr_lce_id_i;
                        if (wr_field_mask_i[1]) w_entry_nxt[i].paddr      = wr_paddr_i;
                        if (wr_field_mask_i[2]) w_entry_nxt[i].way_id     = wr_way_i;
                        if (wr_field_mask_i[3]) w_entry_nxt[i].lru_way_id = wr_lru_way_i;
                        if (wr_field_mask_i[4]) w_entry_nxt[i].coh_state  = wr_coh_state_i;
                        w_entry_nxt[i].flags = (r_entry[i].flags & ~wr_flag_mask_i) |
                                               (wr_flags_i & wr_flag_mask_i);
                    end
                    if (dir_lru_v_i) begin
                        w_entry_nxt[i].lru_paddr             = dir_lru_addr_i;
                        w_entry_nxt[i].flags[lef_flag_idx_p] = dir_lru_cached_excl_i;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_valid <= '0;
            r_count <= '0;
            // NOTE: entry storage is cleared on reset because every field must read as zero afterwards.
            for (int i = 0; i < num_mshr_p; i++) r_entry[i] <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all entries update from the same pre-edge values.
            r_valid <= w_valid_nxt;
            r_count <= r_count + cnt_w'(w_alloc_fire) - cnt_w'(w_free_eff);
            for (int i = 0; i < num_mshr_p; i++) r_entry[i] <= w_entry_nxt[i];
        end
    end

    // Out-of-range read ids match no entry and read as zero.
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < num_mshr_p; i++)
            if (rd_id_i == id_w'(i)) w_rd = r_entry[i];
    end

    assign alloc_ready_o  = ~w_full & ~w_conflict;
    assign alloc_id_o     = w_alloc_id;
    assign conflict_o     = w_conflict;
    assign rd_lce_id_o    = w_rd.lce_id;
    assign rd_paddr_o     = w_rd.paddr;
    assign rd_way_o       = w_rd.way_id;
    assign rd_lru_way_o   = w_rd.lru_way_id;
    assign rd_lru_paddr_o = w_rd.lru_paddr;
    assign rd_coh_state_o = w_rd.coh_state;
    assign rd_flags_o     = w_rd.flags;
    assign valid_o        = r_valid;
    assign count_o        = r_count;
    assign empty_o        = (r_count == '0);
    assign full_o         = w_full;

endmodule
